ram_arbiter: RTL and testbench

- Shares the single 8-bit external SRAM (ramA/ramD/ramWe) between three requesters: video fetch, Z80 CPU and SD-card ROM/snapshot loader.
- Fixed priority: video > cpu > loader, with a starvation override for the loader.
- Sits between the memory map logic (divMMC paging and ROM/RAM decode) and the SRAM pins.
- Runs on the 7 MHz video clock; every access is a fixed two-cycle slot.

---
 rtl/ram_arb_pkg.sv | 21 ++
 rtl/ram_arb_priority.sv | 34 +++
 rtl/ram_arbiter.sv | 176 +++++++++++++++++
 tb/tb_ram_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and defaults for the SRAM arbiter.
// State encoding, requester ids and the default ROM write-protect boundary.
package ram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      VID = 2'd0,
      CPU = 2'd1,
      LDR = 2'd2
   } rid_t;

   localparam int          AW_DEF     = 21;
   localparam int          STARVE_DEF = 8;
   localparam logic [20:0] ROMTOP_DEF = 21'h004000;

endpackage

// File: rtl/ram_arb_priority.sv
// ram_arb_priority: combinational winner select for the SRAM arbiter.
// Video always wins; cpu beats loader unless the loader is starving.
// A masked requester is treated as not requesting.
module ram_arb_priority
   import ram_arb_pkg::*;
(
   input  logic       vid_req,
   input  logic       cpu_req,
   input  logic       ldr_req,
   input  logic [2:0] mask,
   input  logic       starve,
   output logic       gnt,
   output rid_t       gnt_id
);

   logic v, c, l;

   assign v = vid_req & ~mask[0];
   assign c = cpu_req & ~mask[1];
   assign l = ldr_req & ~mask[2];

   // fixed priority with starvation promotion of the loader over cpu only
   always_comb begin
      gnt    = v | c | l;
      gnt_id = VID;
      if (v)
         gnt_id = VID;
      else if (l && (starve || !c))
         gnt_id = LDR;
      else if (c)
         gnt_id = CPU;
   end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one 8-bit SRAM between video, cpu and SD loader.
// Every access is a fixed two-cycle slot (ACCESS, DONE); arbitration runs
// in IDLE and again in DONE so back-to-back grants give one access per 2
// cycles. The address is registered at grant and stays stable through the
// whole write strobe and the following DONE cycle.
// Optional: define RAM_ARB_ROM_WP_EN to block cpu writes below ROMTOP
// (the slot and ack still happen; the loader is never blocked).
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int            AW     = AW_DEF,
   parameter int            STARVE = STARVE_DEF,
   parameter logic [AW-1:0] ROMTOP = AW'(ROMTOP_DEF)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          vidReq,
   input  logic [AW-1:0] vidA,
   output logic [7:0]    vidDo,
   output logic          vidAck,
   input  logic          cpuReq,
   input  logic          cpuWe,
   input  logic [AW-1:0] cpuA,
   input  logic [7:0]    cpuDi,
   output logic [7:0]    cpuDo,
   output logic          cpuAck,
   input  logic          ldrReq,
   input  logic          ldrWe,
   input  logic [AW-1:0] ldrA,
   input  logic [7:0]    ldrDi,
   output logic          ldrAck,
   output logic [AW-1:0] ramA,
   output logic          ramWe,
   output logic [7:0]    ramDo,
   output logic          ramDoe,
   input  logic [7:0]    ramDi
);

   localparam int CW = $clog2(STARVE + 1);

`ifdef RAM_ARB_ROM_WP_EN
   localparam bit WP_EN = 1'b1;
`else
   localparam bit WP_EN = 1'b0;
`endif

   state_t        state;
   rid_t          win;
   logic          win_wr;
   logic [CW-1:0] starve_cnt;

   logic          arb;
   logic          gnt;
   rid_t          gnt_id;
   logic [2:0]    mask;
   logic          starve;
   logic [AW-1:0] sel_a;
   logic [7:0]    sel_d;
   logic          sel_we;
   logic          sel_wp;

   assign arb    = (state == IDLE) || (state == DONE);
   assign starve = (starve_cnt == CW'(STARVE));

   // in DONE the requester just acked still holds req; hide it for one round
   always_comb begin
      mask = 3'b000;
      if (state == DONE) begin
         case (win)
            VID:     mask = 3'b001;
            CPU:     mask = 3'b010;
            LDR:     mask = 3'b100;
            default: mask = 3'b000;
         endcase
      end
   end

   ram_arb_priority u_prio (
      .vid_req (vidReq),
      .cpu_req (cpuReq),
      .ldr_req (ldrReq),
      .mask    (mask),
      .starve  (starve),
      .gnt     (gnt),
      .gnt_id  (gnt_id)
   );

   // route the winner's address/data/direction toward the SRAM registers
   always_comb begin
      sel_a  = vidA;
      sel_d  = 8'h00;
      sel_we = 1'b0;
      case (gnt_id)
         CPU: begin
            sel_a  = cpuA;
            sel_d  = cpuDi;
            sel_we = cpuWe;
         end
         LDR: begin
            sel_a  = ldrA;
            sel_d  = ldrDi;
            sel_we = ldrWe;
         end
         default: ;
      endcase
      sel_wp = WP_EN && (gnt_id == CPU) && cpuWe && (cpuA < ROMTOP);
   end

   // access FSM: registers SRAM pins, read data and ack pulses
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         win    <= VID;
         win_wr <= 1'b0;
         ramA   <= '0;
         ramDo  <= 8'h00;
         ramWe  <= 1'b1;
         ramDoe <= 1'b0;
         vidDo  <= 8'hFF;
         cpuDo  <= 8'hFF;
         vidAck <= 1'b0;
         cpuAck <= 1'b0;
         ldrAck <= 1'b0;
      end else begin
         vidAck <= 1'b0;
         cpuAck <= 1'b0;
         ldrAck <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (gnt) begin
                  state  <= ACCESS;
                  win    <= gnt_id;
                  win_wr <= sel_we;
                  ramA   <= sel_a;
                  ramDo  <= sel_d;
                  ramWe  <= ~(sel_we & ~sel_wp);
                  ramDoe <= sel_we & ~sel_wp;
               end else begin
                  state <= IDLE;
               end
            end
            ACCESS: begin
               state  <= DONE;
               ramWe  <= 1'b1;
               ramDoe <= 1'b0;
               case (win)
                  VID: begin
                     vidAck <= 1'b1;
                     if (!win_wr) vidDo <= ramDi;
                  end
                  CPU: begin
                     cpuAck <= 1'b1;
                     if (!win_wr) cpuDo <= ramDi;
                  end
                  LDR: ldrAck <= 1'b1;
                  default: ;
               endcase
            end
            default: state <= IDLE;
         endcase
      end
   end

   // loader starvation counter: counts lost arbitrations, clears on grant
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (arb && gnt) begin
         if (gnt_id == LDR)
            starve_cnt <= '0;
         else if (ldrReq && !starve)
            starve_cnt <= starve_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed self-checking bench for ram_arbiter.
// Uses a 64 KB SRAM model indexed by ramA[15:0].
module tb_ram_arbiter;

   localparam int AW = 21;

   logic          clock = 1'b0;
   logic          reset;
   logic          vidReq, cpuReq, cpuWe, ldrReq, ldrWe;
   logic [AW-1:0] vidA, cpuA, ldrA;
   logic [7:0]    cpuDi, ldrDi;
   logic [7:0]    vidDo, cpuDo;
   logic          vidAck, cpuAck, ldrAck;
   logic [AW-1:0] ramA;
   logic          ramWe, ramDoe;
   logic [7:0]    ramDo, ramDi;

   logic [7:0]    mem [0:65535];

   int checks = 0;
   int errors = 0;

   ram_arbiter dut (
      .clock (clock), .reset (reset),
      .vidReq(vidReq), .vidA(vidA), .vidDo(vidDo), .vidAck(vidAck),
      .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuA(cpuA), .cpuDi(cpuDi),
      .cpuDo(cpuDo), .cpuAck(cpuAck),
      .ldrReq(ldrReq), .ldrWe(ldrWe), .ldrA(ldrA), .ldrDi(ldrDi),
      .ldrAck(ldrAck),
      .ramA(ramA), .ramWe(ramWe), .ramDo(ramDo), .ramDoe(ramDoe),
      .ramDi(ramDi)
   );

   always #5 clock = ~clock;

   // asynchronous SRAM read, write captured on clock while ramWe is low
   assign ramDi = mem[ramA[15:0]];
   always @(posedge clock) if (!ramWe) mem[ramA[15:0]] = ramDo;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   int     seq [20];
   int     exp_seq [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 2};
   int     n;
   logic [7:0] ackv;
   logic   we_low;

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      mem[16'h5800] = 8'hA5;
      mem[16'h5801] = 8'h11;
      mem[16'h0800] = 8'h5A;
      reset = 1'b1;
      vidReq = 0; cpuReq = 0; cpuWe = 0; ldrReq = 0; ldrWe = 0;
      vidA = '0; cpuA = '0; ldrA = '0; cpuDi = '0; ldrDi = '0;
      tick(); tick();

      // reset values
      chk("rst_ramWe", ramWe, 1);
      chk("rst_ramDoe", ramDoe, 0);
      chk("rst_ramA", ramA, 0);
      chk("rst_ramDo", ramDo, 0);
      chk("rst_acks", {vidAck, cpuAck, ldrAck}, 0);
      chk("rst_vidDo", vidDo, 8'hFF);
      chk("rst_cpuDo", cpuDo, 8'hFF);
      reset = 1'b0;
      tick();

      // lone cpu read
      cpuA = 21'h005800; cpuWe = 0; cpuReq = 1;
      tick();
      chk("rd_ramA", ramA, 21'h005800);
      chk("rd_ramWe_acc", ramWe, 1);
      chk("rd_noack_acc", cpuAck, 0);
      tick();
      chk("rd_ack", cpuAck, 1);
      chk("rd_cpuDo", cpuDo, 8'hA5);
      chk("rd_ramWe_done", ramWe, 1);
      cpuReq = 0;
      tick();
      chk("rd_ack_pulse", cpuAck, 0);

      // lone loader write
      ldrA = 21'h000100; ldrDi = 8'h3C; ldrWe = 1; ldrReq = 1;
      tick();
      chk("wr_ramWe_acc", ramWe, 0);
      chk("wr_ramDoe_acc", ramDoe, 1);
      chk("wr_ramDo", ramDo, 8'h3C);
      chk("wr_ramA", ramA, 21'h000100);
      chk("wr_noack_acc", ldrAck, 0);
      tick();
      chk("wr_ramWe_done", ramWe, 1);
      chk("wr_ramDoe_done", ramDoe, 0);
      chk("wr_ack", ldrAck, 1);
      chk("wr_mem", mem[16'h0100], 8'h3C);
      ldrReq = 0; ldrWe = 0;
      tick();

      // lone video read
      vidA = 21'h000800; vidReq = 1;
      tick(); tick();
      chk("vid_ack", vidAck, 1);
      chk("vid_do", vidDo, 8'h5A);
      vidReq = 0;
      tick(); tick();

      // cpu holds req across ack: masked in DONE, regranted from IDLE
      cpuA = 21'h005801; cpuReq = 1; ackv = '0;
      for (int t = 1; t <= 8; t++) begin
         tick();
         ackv[t-1] = cpuAck;
         if (t == 2) begin
            chk("b2b_do1", cpuDo, 8'h11);
            mem[16'h5801] = 8'h22;
         end
         if (t == 5) begin
            chk("b2b_do2", cpuDo, 8'h22);
            cpuReq = 0;
         end
      end
      chk("b2b_ack_pattern", ackv, 8'h12);

      // all three requesting continuously: starvation promotes loader
      vidA = 21'h000800; cpuA = 21'h005800; ldrA = 21'h000100; ldrWe = 0;
      vidReq = 1; cpuReq = 1; ldrReq = 1; n = 0;
      for (int t = 0; t < 100 && n < 20; t++) begin
         tick();
         if (vidAck) seq[n++] = 0;
         else if (cpuAck) seq[n++] = 1;
         else if (ldrAck) seq[n++] = 2;
      end
      vidReq = 0; cpuReq = 0; ldrReq = 0;
      chk("arb_count", n, 20);
      for (int i = 0; i < n; i++) chk($sformatf("arb_seq%0d", i), seq[i], exp_seq[i % 10]);
      tick(); tick();

      // reset during the ACCESS cycle of a write
      cpuA = 21'h000200; cpuDi = 8'h55; cpuWe = 1; cpuReq = 1;
      tick();
      chk("rstw_ramWe_acc", ramWe, 0);
      reset = 1'b1;
      #1;
      chk("rstw_ramWe", ramWe, 1);
      chk("rstw_ramDoe", ramDoe, 0);
      chk("rstw_cpuDo", cpuDo, 8'hFF);
      tick();
      chk("rstw_noack", cpuAck, 0);
      reset = 1'b0;
      tick();
      chk("rstw_regrant_we", ramWe, 0);
      chk("rstw_regrant_ramA", ramA, 21'h000200);
      tick();
      chk("rstw_regrant_ack", cpuAck, 1);
      chk("rstw_mem", mem[16'h0200], 8'h55);
      cpuReq = 0; cpuWe = 0;
      tick();

      // write to the ROM region from cpu, then from the loader
      cpuA = 21'h001000; cpuDi = 8'h77; cpuWe = 1; cpuReq = 1; we_low = 0;
      tick(); we_low |= ~ramWe;
      tick(); we_low |= ~ramWe;
      chk("rom_cpu_ack", cpuAck, 1);
`ifdef RAM_ARB_ROM_WP_EN
      chk("rom_cpu_we_low", we_low, 0);
      chk("rom_cpu_mem", mem[16'h1000], 8'h00);
`else
      chk("rom_cpu_we_low", we_low, 1);
      chk("rom_cpu_mem", mem[16'h1000], 8'h77);
`endif
      cpuReq = 0; cpuWe = 0;
      tick();
      ldrA = 21'h001000; ldrDi = 8'h99; ldrWe = 1; ldrReq = 1; we_low = 0;
      tick(); we_low |= ~ramWe;
      tick(); we_low |= ~ramWe;
      chk("rom_ldr_ack", ldrAck, 1);
      chk("rom_ldr_we_low", we_low, 1);
      chk("rom_ldr_mem", mem[16'h1000], 8'h99);
      ldrReq = 0; ldrWe = 0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
